core_run_ctrl: RTL

CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

---
 rtl/core_run_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/core_run_ctrl.sv
// Run controller for a debug-target core: holds it in reset, lets it run until a breakpoint,
// a cycle budget or (with CORE_RUN_CTRL_STUCK_EN defined) a stalled PC halts it.
module core_run_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int NUM_BP       = 2,
  parameter int RST_CYCLES   = 2,
  parameter int MAX_CYCLES   = 50,
  parameter int CNT_W        = 16,
  parameter int STUCK_CYCLES = 8,
  localparam int HIT_W       = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  input  logic [ADDR_W-1:0]        pc_current,
  output logic                     core_rst,
  output logic                     core_clk_en,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  output logic                     stuck,
  output logic [HIT_W-1:0]         hit_idx,
  output logic [CNT_W-1:0]         cycle_count
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CYCLES);

  generate
    if (NUM_BP < 1 || NUM_BP > 8 || RST_CYCLES < 1 || MAX_CYCLES < 1 || STUCK_CYCLES < 1 ||
        (longint'(MAX_CYCLES) >> CNT_W) != 0) begin : g_bad_params
      $error("core_run_ctrl: illegal parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic [HIT_W-1:0]  hit_q, hit_d;
  logic              match;
  logic [HIT_W-1:0]  match_idx;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Descending scan so the lowest matching channel wins.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (pc_current == bp_addr[i*ADDR_W +: ADDR_W])) begin
        match     = 1'b1;
        match_idx = HIT_W'(i);
      end
    end
  end

`ifdef CORE_RUN_CTRL_STUCK_EN
  localparam int SC_W = $clog2(STUCK_CYCLES + 1);

  logic [SC_W-1:0]   same_cnt_q, same_cnt_d, run_len;
  logic [ADDR_W-1:0] prev_pc_q;
  logic              stuck_q, stuck_d;
  logic              stuck_hit;

  // run_len counts consecutive RUN edges sharing one PC; zero means no previous sample yet.
  always_comb begin
    run_len = SC_W'(1);
    if ((same_cnt_q != '0) && (pc_current == prev_pc_q))
      run_len = same_cnt_q + SC_W'(1);
  end

  assign stuck_hit = (run_len == SC_W'(STUCK_CYCLES));

  always_ff @(posedge clk) begin
    if (state_q == S_RUN)
      prev_pc_q <= pc_current;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      same_cnt_q <= '0;
      stuck_q    <= 1'b0;
    end else begin
      same_cnt_q <= same_cnt_d;
      stuck_q    <= stuck_d;
    end
  end

  assign stuck = stuck_q;
`else
  assign stuck = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    hit_d     = hit_q;
`ifdef CORE_RUN_CTRL_STUCK_EN
    same_cnt_d = same_cnt_q;
    stuck_d    = stuck_q;
`endif
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d   = S_RESET;
          rst_cnt_d = '0;
          cnt_d     = '0;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          hit_d     = '0;
`ifdef CORE_RUN_CTRL_STUCK_EN
          stuck_d   = 1'b0;
`endif
        end
      end
      S_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
`ifdef CORE_RUN_CTRL_STUCK_EN
          same_cnt_d = '0;
`endif
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
`ifdef CORE_RUN_CTRL_STUCK_EN
        same_cnt_d = run_len;
`endif
        if (match) begin
          done_d  = 1'b1;
          hit_d   = match_idx;
          state_d = S_HALT;
        end
`ifdef CORE_RUN_CTRL_STUCK_EN
        else if (stuck_hit) begin
          stuck_d = 1'b1;
          state_d = S_HALT;
        end
`endif
        else if (cnt_inc == MAX_CNT) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rst_cnt_q <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      hit_q     <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      hit_q     <= hit_d;
    end
  end

  assign core_rst    = (state_q == S_IDLE) || (state_q == S_RESET);
  assign core_clk_en = (state_q == S_RESET) || (state_q == S_RUN);
  assign busy        = core_clk_en;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign hit_idx     = hit_q;
  assign cycle_count = cnt_q;

endmodule
